// File: rtl/solution_reader.sv
// rtl/solution_reader.sv - collects iterative solver sweeps and streams out the final sweep
module solution_reader #(
    parameter int N  = 16,
    parameter int DW = 32,
    parameter int IW = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [IW-1:0]         iter_in,
    input  logic                  x_valid_in,
    input  logic [DW-1:0]         x_in,
    input  logic                  out_ready_in,
    output logic                  out_valid_out,
    output logic [DW-1:0]         out_data_out,
    output logic [$clog2(N)-1:0]  out_index_out,
    output logic                  out_last_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  overrun_out
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_idx_q;
    logic [AW-1:0]   rd_idx_q;
    logic [IW-1:0]   sweep_q;
    logic [IW-1:0]   sweep_d;
    logic [IW-1:0]   target_q;
    logic            done_q;
    logic            overrun_q;
    logic [DW-1:0]   buf_q [N];

    assign sweep_d = sweep_q + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            sweep_q   <= '0;
            target_q  <= IW'(1);
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        target_q  <= (iter_in == '0) ? IW'(1) : iter_in;
                        wr_idx_q  <= '0;
                        rd_idx_q  <= '0;
                        sweep_q   <= '0;
                        overrun_q <= 1'b0;
                        state_q   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (x_valid_in) begin
                        wr_idx_q <= (wr_idx_q == LAST) ? '0 : wr_idx_q + 1'b1;
                        // Only a completed sweep counts toward the target.
                        if (wr_idx_q == LAST) begin
                            sweep_q <= sweep_d;
                            if (sweep_d == target_q) begin
                                rd_idx_q <= '0;
                                state_q  <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (x_valid_in) overrun_q <= 1'b1;
                    if (out_ready_in) begin
                        if (rd_idx_q == LAST) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer is deliberately not reset; its contents only matter once a full sweep lands.
    always_ff @(posedge clk_in) begin
        if (state_q == COLLECT && x_valid_in) buf_q[wr_idx_q] <= x_in;
    end

    assign out_valid_out = (state_q == DRAIN);
    assign out_data_out  = buf_q[rd_idx_q];
    assign out_index_out = out_valid_out ? rd_idx_q : '0;
    assign out_last_out  = out_valid_out && (rd_idx_q == LAST);
    assign busy_out      = (state_q != IDLE);
    assign done_out      = done_q;
    assign overrun_out   = overrun_q;
endmodule
